// File: rtl/axis_fifo_arbiter.sv
// axis_fifo_arbiter
// Round-robin burst arbiter feeding the write side of one shared axis_fifo.
// A producer is granted a whole burst only when the FIFO reports room for it,
// so the FIFO never has to back-pressure in the middle of a burst.
// Optional feature macro: AXIS_FIFO_ARBITER_TIMEOUT_EN (stall timeout abort).
// fsm_state exposes the controller state (0 idle, 1 burst, 2 settle).
//
// Handshake: a beat moves on a cycle where the sender holds valid high and the
// receiver holds ready high in the same cycle; valid never waits on ready.
// Here the granted producer's valid/data are passed straight to m_axis and
// m_axis_tready is passed straight back to that producer only.
module axis_fifo_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 512,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [15:0]                     cfg_burst,
  input  logic [15:0]                     write_count,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            timeout,
  output logic [1:0]                      fsm_state
);

  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [16:0] DEPTH17 = 17'(FIFO_DEPTH);

  // Reject configurations the counters and pointer arithmetic cannot handle.
  if (NUM_PORTS < 2 || NUM_PORTS > 16 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1
      || FIFO_DEPTH < 1 || FIFO_DEPTH > 131071) begin : g_param_check
    $error("axis_fifo_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       gnt_idx_q, gnt_idx_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [15:0]            len_q, len_d;
  logic [15:0]            beat_q, beat_d;
  logic [SET_W-1:0]       settle_q, settle_d;

  logic [DATA_WIDTH-1:0]  port_data [NUM_PORTS];
  logic [PTR_W-1:0]       cand [NUM_PORTS];
  logic [PTR_W-1:0]       sel_idx;
  logic [PTR_W-1:0]       ptr_adv;
  logic                   found;
  logic [15:0]            len_eff;
  logic [15:0]            beat_inc;
  logic [16:0]            wc17;
  logic                   room;
  logic                   in_burst;
  logic                   hs;
  logic                   last_beat;
  logic                   abort;

  // Split the flat producer data bus into one word per port.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign port_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Burst length 0 is treated as a single beat.
  assign len_eff = (cfg_burst == 16'd0) ? 16'd1 : cfg_burst;

  // Room check in 17 bits; an over-full count means no room at all.
  assign wc17 = {1'b0, write_count};
  assign room = (wc17 <= DEPTH17) && ((DEPTH17 - wc17) >= {1'b0, len_eff});

  // Round-robin search: first valid port at or after the pointer, wrapping.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand[k] = PTR_W'((int'(ptr_q) + k) % NUM_PORTS);
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && s_axis_tvalid[cand[k]]) begin
        found   = 1'b1;
        sel_idx = cand[k];
      end
    end
  end

  // Zero-latency datapath from the granted producer to the FIFO.
  assign in_burst      = (state_q == ST_BURST);
  assign m_axis_tvalid = in_burst & s_axis_tvalid[gnt_idx_q];
  assign m_axis_tdata  = in_burst ? port_data[gnt_idx_q] : '0;
  assign s_axis_tready = (in_burst & m_axis_tready) ? grant_q : '0;
  assign hs            = m_axis_tvalid & m_axis_tready;

  assign beat_inc  = beat_q + 16'd1;
  assign last_beat = hs && (beat_inc == len_q);
  assign ptr_adv   = (gnt_idx_q == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx_q + 1'b1;

  assign grant     = grant_q;
  assign fsm_state = state_q;

`ifdef AXIS_FIFO_ARBITER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_q, stall_d;

  // Abort on the cycle the run of handshake-free burst cycles reaches the limit.
  assign abort   = in_burst && !hs && (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));
  assign timeout = abort;

  // Stall counter: counts consecutive burst cycles without a handshake.
  always_comb begin
    stall_d = '0;
    if (in_burst && !hs && !abort) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  // Without the timeout feature a stalled burst simply waits.
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

  // Next-state logic: grant decision in IDLE, beat counting in BURST,
  // fixed quiet gap in SETTLE while write_count catches up.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    grant_d   = grant_q;
    len_d     = len_q;
    beat_d    = beat_q;
    settle_d  = settle_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found && room) begin
          state_d   = ST_BURST;
          gnt_idx_d = sel_idx;
          grant_d   = NUM_PORTS'(1) << sel_idx;
          len_d     = len_eff;
          beat_d    = '0;
        end
      end
      ST_BURST: begin
        if (hs) begin
          beat_d = beat_inc;
        end
        if (last_beat || abort) begin
          state_d  = ST_SETTLE;
          grant_d  = '0;
          ptr_d    = ptr_adv;
          settle_d = '0;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State register with synchronous reset; a partial burst is dropped.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      grant_q   <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      grant_q   <= grant_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      settle_q  <= settle_d;
    end
  end

endmodule

// File: tb/tb_axis_fifo_arbiter.sv
// tb_axis_fifo_arbiter
// Bench for axis_fifo_arbiter (default build, timeout feature not compiled in).
// A transaction-level model (busy port, beats left, quiet cycles, pointer)
// predicts grant/valid/ready/data every cycle; a queue scoreboard checks that
// every beat reaching the FIFO side is the expected word, once.
module tb_axis_fifo_arbiter;

  localparam int NP     = 4;
  localparam int DW     = 32;
  localparam int DEPTH  = 512;
  localparam int SETTLE = 2;
  localparam int TOUT   = 10;

  // ---------------- clock / reset ----------------
  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [15:0]       cfg_burst = '0;
  logic [15:0]       write_count = '0;
  logic [NP*DW-1:0]  s_axis_tdata = '0;
  logic [NP-1:0]     s_axis_tvalid = '0;
  logic [NP-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic [NP-1:0]     grant;
  logic              timeout;
  logic [1:0]        fsm_state;

  always #5 aclk = ~aclk;

  axis_fifo_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .aclk(aclk), .areset(areset), .cfg_burst(cfg_burst), .write_count(write_count),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .grant(grant), .timeout(timeout), .fsm_state(fsm_state)
  );

  // ---------------- counters, model, scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;

  int busy = -1;
  int left = 0;
  int ptr = 0;
  int quiet = SETTLE;
  int seq [NP];
  logic [DW-1:0] exp_q[$];

  int start_q[$];
  int beats_q[$];
  int gap_q[$];
  logic [NP-1:0] prev_grant = '0;
  logic [DW-1:0] last_tdata = '0;
  logic          last_tvalid = 1'b0;
  int idle_run = 0;
  int cur_beats = 0;
  int total_hs = 0;
  int to_seen = 0;
  int rdy_viol = 0;

  typedef struct {
    int wc;
    int burst;
    int exp_beats;
  } room_vec_t;
  room_vec_t tbl [9];

  function automatic logic [DW-1:0] word(int p);
    logic [7:0]  tag;
    logic [23:0] cnt;
    tag = 8'(p);
    cnt = 24'(seq[p]);
    return {tag, cnt};
  endfunction

  function automatic int onehot_idx(logic [NP-1:0] v);
    for (int i = 0; i < NP; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_obs();
    start_q.delete();
    beats_q.delete();
    gap_q.delete();
    idle_run = 0;
    cur_beats = 0;
    total_hs = 0;
    to_seen = 0;
    rdy_viol = 0;
  endtask

  // One clock cycle: check outputs against the model, advance the model,
  // then drive fresh producer words at the next falling edge.
  task automatic step();
    logic [NP-1:0] eg;
    logic [NP-1:0] er;
    logic          ev;
    logic [DW-1:0] sb_front;
    bit            hs;
    int            len_l;
    #2;
    eg = '0;
    er = '0;
    ev = 1'b0;
    if (busy >= 0) begin
      eg[busy] = 1'b1;
      ev = s_axis_tvalid[busy];
      if (m_axis_tready) er[busy] = 1'b1;
    end
    chk("grant", 32'(grant), 32'(eg));
    chk("m_tvalid", 32'(m_axis_tvalid), 32'(ev));
    chk("s_tready", 32'(s_axis_tready), 32'(er));
    chk("timeout", 32'(timeout), 32'd0);
    if (ev) chk("m_tdata", m_axis_tdata, word(busy));

    hs = ev && m_axis_tready;
    if (hs) exp_q.push_back(word(busy));
    if (m_axis_tvalid && m_axis_tready) begin
      sb_front = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk("sb_beat", m_axis_tdata, sb_front);
    end

    // Reference model of the arbitration rules.
    if (hs) begin
      seq[busy]++;
      left--;
      if (left == 0) begin
        ptr = (busy + 1) % NP;
        busy = -1;
        quiet = 0;
      end
    end else if (busy < 0) begin
      if (quiet >= SETTLE) begin
        len_l = (cfg_burst == 16'd0) ? 1 : int'(cfg_burst);
        if (int'(write_count) <= DEPTH && (DEPTH - int'(write_count)) >= len_l) begin
          for (int k = 0; k < NP; k++) begin
            if (busy < 0 && s_axis_tvalid[(ptr + k) % NP]) begin
              busy = (ptr + k) % NP;
              left = len_l;
            end
          end
        end
      end else begin
        quiet++;
      end
    end
    if (areset) begin
      busy = -1;
      left = 0;
      ptr = 0;
      quiet = SETTLE;
    end

    // Observations for the scenario checks.
    if (grant != '0 && prev_grant == '0) begin
      start_q.push_back(onehot_idx(grant));
      gap_q.push_back(idle_run);
      cur_beats = 0;
    end
    if (grant == '0 && prev_grant != '0) beats_q.push_back(cur_beats);
    if (grant != '0 && m_axis_tvalid && m_axis_tready) cur_beats++;
    if (m_axis_tvalid && m_axis_tready) total_hs++;
    if (timeout) to_seen++;
    if (grant == '0) idle_run++;
    else idle_run = 0;
    if (grant[1] && s_axis_tready[2]) rdy_viol++;
    prev_grant = grant;
    last_tdata = m_axis_tdata;
    last_tvalid = m_axis_tvalid;

    @(negedge aclk);
    for (int i = 0; i < NP; i++) s_axis_tdata[i*DW +: DW] = word(i);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
    clear_obs();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < NP; i++) seq[i] = 0;
    tbl[0] = '{497, 16, 0};
    tbl[1] = '{496, 16, 16};
    tbl[2] = '{512, 0, 0};
    tbl[3] = '{511, 0, 1};
    tbl[4] = '{513, 1, 0};
    tbl[5] = '{0, 513, 0};
    tbl[6] = '{0, 512, 512};
    tbl[7] = '{65535, 1, 0};
    tbl[8] = '{100, 1, 1};

    repeat (2) @(negedge aclk);
    for (int i = 0; i < NP; i++) s_axis_tdata[i*DW +: DW] = word(i);

    // Reset state.
    do_reset();
    chk("reset_state", 32'(fsm_state), 32'd0);
    chk("reset_grant", 32'(grant), 32'd0);

    // Round-robin fairness: 8-beat bursts, everyone valid.
    cfg_burst = 16'd8;
    write_count = 16'd0;
    s_axis_tvalid = '1;
    m_axis_tready = 1'b1;
    repeat (60) step();
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_order[%0d]", i), 32'((i < start_q.size()) ? start_q[i] : -1), 32'(i % 4));
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_beats[%0d]", i), 32'((i < beats_q.size()) ? beats_q[i] : -1), 32'd8);
    for (int i = 1; i < 5; i++)
      chk($sformatf("rr_gap[%0d]", i), 32'((i < gap_q.size()) ? gap_q[i] : -1), 32'd3);

    // Room check table.
    for (int t = 0; t < 9; t++) begin
      int n;
      do_reset();
      cfg_burst = 16'(tbl[t].burst);
      write_count = 16'(tbl[t].wc);
      s_axis_tvalid = '1;
      m_axis_tready = 1'b1;
      n = (tbl[t].exp_beats > 0) ? tbl[t].exp_beats + 3 : 12;
      repeat (n) step();
      s_axis_tvalid = '0;
      repeat (6) step();
      chk($sformatf("room_beats[%0d]", t), 32'(total_hs), 32'(tbl[t].exp_beats));
      chk($sformatf("room_grants[%0d]", t), 32'(start_q.size()), 32'((tbl[t].exp_beats > 0) ? 1 : 0));
    end

    // Room opens up: 497 blocks, 496 lets a 16-beat burst through.
    do_reset();
    cfg_burst = 16'd16;
    write_count = 16'd497;
    s_axis_tvalid = '1;
    repeat (10) step();
    chk("room_497_nogrant", 32'(start_q.size()), 32'd0);
    write_count = 16'd496;
    total_hs = 0;
    repeat (18) step();
    s_axis_tvalid = '0;
    repeat (5) step();
    chk("room_496_beats", 32'(total_hs), 32'd16);
    chk("room_496_port", 32'((start_q.size() > 0) ? start_q[0] : -1), 32'd0);

    // Atomic burst: port1 valid 1,0,0,..., port2 always valid.
    do_reset();
    cfg_burst = 16'd8;
    write_count = 16'd0;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      s_axis_tvalid = {1'b0, 1'b1, (k % 3 == 0), 1'b0};
      step();
    end
    s_axis_tvalid = '0;
    repeat (4) step();
    chk("atomic_first", 32'((start_q.size() > 0) ? start_q[0] : -1), 32'd1);
    chk("atomic_second", 32'((start_q.size() > 1) ? start_q[1] : -1), 32'd2);
    chk("atomic_beats", 32'((beats_q.size() > 0) ? beats_q[0] : -1), 32'd8);
    chk("atomic_ready2", 32'(rdy_viol), 32'd0);

    // Backpressure on 1-beat bursts (cfg_burst = 0).
    do_reset();
    cfg_burst = 16'd0;
    s_axis_tvalid = '1;
    m_axis_tready = 1'b0;
    for (int g = 0; g < 10 && prev_grant == '0; g++) step();
    chk("bp_granted", 32'(prev_grant), 32'd1);
    begin
      logic [DW-1:0] held;
      held = last_tdata;
      for (int h = 0; h < 5; h++) begin
        step();
        chk($sformatf("bp_hold_data[%0d]", h), last_tdata, held);
        chk($sformatf("bp_hold_valid[%0d]", h), 32'(last_tvalid), 32'd1);
      end
    end
    m_axis_tready = 1'b1;
    repeat (30) step();
    s_axis_tvalid = '0;
    repeat (5) step();
    for (int i = 0; i < beats_q.size(); i++)
      chk($sformatf("bp_len1[%0d]", i), 32'(beats_q[i]), 32'd1);

    // Reset mid-burst: port1 then port2 bursts, reset after 3 beats of port2.
    do_reset();
    cfg_burst = 16'd8;
    s_axis_tvalid = 4'b0110;
    m_axis_tready = 1'b1;
    for (int g = 0; g < 40 && !(start_q.size() == 2 && cur_beats == 3); g++) step();
    chk("rst_pre_beats", 32'(cur_beats), 32'd3);
    s_axis_tvalid = '1;
    areset = 1'b1;
    step();
    areset = 1'b0;
    step();
    chk("rst_grant", 32'(prev_grant), 32'd0);
    chk("rst_tvalid", 32'(last_tvalid), 32'd0);
    clear_obs();
    repeat (4) step();
    chk("rst_first_port", 32'((start_q.size() > 0) ? start_q[0] : -1), 32'd0);
    s_axis_tvalid = '0;
    repeat (12) step();

    // Stalled producer: without the timeout feature the grant just holds.
    do_reset();
    cfg_burst = 16'd8;
    s_axis_tvalid = 4'b0001;
    m_axis_tready = 1'b1;
    for (int g = 0; g < 20 && cur_beats < 2; g++) step();
    chk("to_two_beats", 32'(cur_beats), 32'd2);
    s_axis_tvalid = '0;
    to_seen = 0;
    repeat (15) step();
    chk("to_no_pulse", 32'(to_seen), 32'd0);
    chk("to_grant_held", 32'(prev_grant), 32'd1);
    s_axis_tvalid = 4'b0001;
    repeat (12) step();
    s_axis_tvalid = '0;
    repeat (4) step();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      s_axis_tvalid = NP'($urandom);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      if (c % 25 == 0) cfg_burst = 16'($urandom_range(0, 5));
      write_count = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(506, 514))
                                               : 16'($urandom_range(0, 20));
      areset = ($urandom_range(0, 399) == 0);
      step();
    end
    areset = 1'b0;
    s_axis_tvalid = '0;
    repeat (5) step();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_fifo_arbiter.md
# axis_fifo_arbiter

Round-robin burst arbiter that shares the write side of one `axis_fifo` between `NUM_PORTS` AXI4-Stream producers.
- Each grant moves an atomic burst of `cfg_burst` beats from one producer to the FIFO input.
- A burst is granted only when the FIFO's `write_count` shows room for the whole burst, so the FIFO never back-pressures mid-burst.
- The block sits between the acquisition or DMA sources and the `s_axis` port of the shared FIFO.

## Interface
- `NUM_PORTS`, 4: number of producer streams (2..16).
- `DATA_WIDTH`, 32: tdata width of every stream.
- `FIFO_DEPTH`, 512: write depth of the downstream FIFO, in words.
- `SETTLE_CYCLES`, 2: idle gap after each burst, covering `write_count` update latency (≥1).
- `TIMEOUT_CYCLES`, 1024: stall limit; used only when the timeout feature is compiled in.

Ports:
- `aclk` input 1: clock.
- `areset` input 1: reset. Synchronous, active-high.
- `cfg_burst` input 16: burst length in beats. Value 0 is treated as 1.
- `write_count` input 16: FIFO occupancy, driven from the FIFO's `write_count`.
- `s_axis_tdata` input NUM_PORTS*DATA_WIDTH: producer data. Port i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_axis_tvalid` input NUM_PORTS: producer valid, one bit per port.
- `s_axis_tready` output NUM_PORTS: producer ready, one bit per port.
- `m_axis_tdata` output DATA_WIDTH: data to the FIFO.
- `m_axis_tvalid` output 1: valid to the FIFO.
- `m_axis_tready` input 1: ready from the FIFO.
- `grant` output NUM_PORTS: one-hot registered grant. All zero when no burst is active.
- `timeout` output 1: one-cycle pulse when a burst is aborted.

## Operation
- State machine: IDLE → BURST → SETTLE → IDLE.
- Reset state:
  - State is IDLE; `grant`, round-robin pointer and beat counter are 0.
  - `m_axis_tvalid`, `s_axis_tready` and `timeout` are 0.
- IDLE:
  - Effective length `len = max(cfg_burst, 1)`.
  - Room check: `FIFO_DEPTH - write_count >= len`, evaluated in 17-bit unsigned arithmetic. If `write_count > FIFO_DEPTH`, there is no room.
  - Search ports starting at the pointer, wrapping modulo `NUM_PORTS`. Pick the first port with `s_axis_tvalid` high.
  - If a port is found and there is room: register the one-hot `grant`, latch `len`, clear the beat counter, go to BURST.
  - Otherwise stay in IDLE.
  - If `len > FIFO_DEPTH`, no burst is ever granted.
- BURST:
  - `m_axis_tdata` is the granted port's data; `m_axis_tvalid` is the granted port's valid.
  - Only the granted port sees `s_axis_tready = m_axis_tready`; all other ready bits are 0.
  - This path is combinational, with zero added latency.
  - The beat counter increments on each handshake (`m_axis_tvalid & m_axis_tready`).
  - On the handshake that makes the count equal the latched `len`:
    - Go to SETTLE and clear `grant`.
    - Set the pointer to the granted index + 1, modulo `NUM_PORTS`.
  - A burst is atomic. If the producer drops valid, the arbiter waits, and other ports are never served mid-burst.
- SETTLE: hold all outputs inactive for `SETTLE_CYCLES` cycles, then go to IDLE.
- Changes to `cfg_burst` during BURST or SETTLE have no effect until the next IDLE evaluation.
- Reset asserted in any state returns all state to reset values on the next edge. A partial burst is abandoned; no beat is replayed.

## Timing
- Grant decision: registered. The first beat can complete in the cycle after the IDLE cycle in which the conditions held.
- Minimum spacing between bursts: last beat, then `SETTLE_CYCLES` idle cycles, then 1 IDLE cycle, then the first beat of the next burst.
- A burst of length L with continuous valid/ready takes exactly L cycles in BURST.
- `m_axis_tvalid` never asserts outside BURST.

## Configuration
- Macro: `AXIS_FIFO_ARBITER_TIMEOUT_EN`.
- Defined:
  - In BURST, a stall counter counts consecutive cycles without a handshake and clears on each handshake.
  - When it reaches `TIMEOUT_CYCLES`, the burst is aborted: `timeout` pulses for 1 cycle, the pointer advances past the granted port, and the state goes to SETTLE.
- Not defined: no stall counter is built, `timeout` is tied to 0, and bursts wait indefinitely.

## Test plan
- Round-robin fairness: `NUM_PORTS`=4, `cfg_burst`=8, all four valid continuously, `write_count`=0, `m_axis_tready`=1 → grants in order port0, 1, 2, 3, 0; exactly 8 beats each; exactly 3 idle cycles between bursts.
- Room check: `FIFO_DEPTH`=512, `cfg_burst`=16.
  - `write_count`=497 → no grant.
  - Drop `write_count` to 496 → grant on the next IDLE evaluation, 16 beats delivered.
- Atomic burst with stalls: port1 valid toggling 1,0,0,1… with ready=1 and port2 valid throughout → all `cfg_burst` beats come from port1 before port2 gets a grant; `s_axis_tready[2]`=0 for the whole burst.
- Backpressure and length corner: `cfg_burst`=0 → 1-beat bursts. With `m_axis_tready` low for 5 cycles mid-burst, the data word on the held beat is stable and no beat is lost or duplicated (checked with a scoreboard).
- Reset: assert `areset` after 3 of 8 beats → next cycle `grant`=0, `m_axis_tvalid`=0, pointer=0. After release, port0 is granted first.
- Timeout (macro defined): `TIMEOUT_CYCLES`=10, granted port drops valid after 2 beats → `timeout` pulses once 10 cycles after the last beat and the next port is granted. Without the macro, `timeout` stays 0 and the grant holds.
